// File: rtl/if_id_skid_register_if.sv
// Valid/ready channel carrying one PC+4 / instruction pair between pipeline stages.
// The master drives valid and payload; the slave drives ready.
interface if_id_skid_register_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   valid;
    logic                   ready;
    logic [PC_WIDTH-1:0]    pc_4;
    logic [INSTR_WIDTH-1:0] instruction;

    modport master (
        output valid,
        output pc_4,
        output instruction,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc_4,
        input  instruction,
        output ready
    );
endinterface

// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with a 2-entry skid buffer: accepted fetch data reaches decode one
// cycle later; decode backpressure parks one overflow entry and then drops the registered ready.
module if_id_skid_register #(
    parameter int unsigned            PC_WIDTH        = 32,
    parameter int unsigned            INSTR_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    PC_RESET        = PC_WIDTH'(4),
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = '0,
    parameter int unsigned            COUNT_WIDTH     = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    if_id_skid_register_if.slave    fetch,
    if_id_skid_register_if.master   decode,
    output logic [COUNT_WIDTH-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
    logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic in_fire;
    logic out_fire;
    logic stalled;

    assign in_fire  = fetch.valid & ready_q;
    assign out_fire = valid_q & decode.ready;
    assign stalled  = valid_q & ~decode.ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            main_pc_q    <= PC_RESET;
            main_instr_q <= NOP_INSTRUCTION;
            skid_pc_q    <= PC_RESET;
            skid_instr_q <= NOP_INSTRUCTION;
            valid_q      <= 1'b0;
            ready_q      <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = FULL;
                    main_pc_d    = fetch.pc_4;
                    main_instr_d = fetch.instruction;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_pc_d    = fetch.pc_4;
                    main_instr_d = fetch.instruction;
                end else if (in_fire) begin
                    state_d      = SKID;
                    skid_pc_d    = fetch.pc_4;
                    skid_instr_d = fetch.instruction;
                end else if (out_fire) begin
                    state_d      = EMPTY;
                    main_pc_d    = PC_RESET;
                    main_instr_d = NOP_INSTRUCTION;
                end
            end
            SKID: begin
                // if_ready is low here, so no new entry can arrive to overwrite the skid slot.
                if (out_fire) begin
                    state_d      = FULL;
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                end
            end
            default: begin
                state_d      = EMPTY;
                main_pc_d    = PC_RESET;
                main_instr_d = NOP_INSTRUCTION;
            end
        endcase

        // A redirect beats everything: the wrong-path fetch and any parked entry are dropped.
        if (flush) begin
            state_d      = EMPTY;
            main_pc_d    = PC_RESET;
            main_instr_d = NOP_INSTRUCTION;
            skid_pc_d    = PC_RESET;
            skid_instr_d = NOP_INSTRUCTION;
        end

        valid_d = (state_d != EMPTY);
        ready_d = (state_d != SKID);
    end

    always_comb begin
        count_d = count_q;
        if (stalled && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    assign fetch.ready        = ready_q;
    assign decode.valid       = valid_q;
    assign decode.pc_4        = main_pc_q;
    assign decode.instruction = main_instr_q;
    assign stall_cycles       = count_q;

    // A payload offered to decode must not move until decode takes it.
    a_payload_stable: assert property (
        @(posedge clock) disable iff (!reset_n)
        (valid_q && !decode.ready && !flush) |=>
            (valid_q && main_pc_q == $past(main_pc_q) && main_instr_q == $past(main_instr_q))
    );

    a_ready_matches_state: assert property (
        @(posedge clock) disable iff (!reset_n)
        ready_q == (state_q != SKID)
    );

endmodule

// File: tb/tb_if_id_skid_register.sv
module tb_if_id_skid_register;
    localparam int unsigned PW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned CW = 4;

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic [CW-1:0] stall_cycles;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    if_id_skid_register_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) fetch_ch ();
    if_id_skid_register_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) decode_ch ();

    if_id_skid_register #(
        .PC_WIDTH        (PW),
        .INSTR_WIDTH     (IW),
        .PC_RESET        (32'd4),
        .NOP_INSTRUCTION (32'd0),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .fetch        (fetch_ch.slave),
        .decode       (decode_ch.master),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] pc, input logic [IW-1:0] ins,
                         input logic rdy);
        fetch_ch.valid       = v;
        fetch_ch.pc_4        = pc;
        fetch_ch.instruction = ins;
        decode_ch.ready      = rdy;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [PW-1:0] pc,
                              input logic [IW-1:0] ins, input logic rdy);
        check({tag, ".id_valid"}, 64'(decode_ch.valid), 64'(v));
        check({tag, ".id_pc_4"}, 64'(decode_ch.pc_4), 64'(pc));
        check({tag, ".id_instr"}, 64'(decode_ch.instruction), 64'(ins));
        check({tag, ".if_ready"}, 64'(fetch_ch.ready), 64'(rdy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step();
        step();
        expect_out("reset", 1'b0, 32'd4, 32'd0, 1'b1);
        check("reset.stall", 64'(stall_cycles), 64'd0);
        reset_n = 1'b1;

        // Streaming: one entry per cycle, in order, no stalls.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(8 + 4 * i), 32'(32'h1000 + i), 1'b1);
            step();
            expect_out($sformatf("stream%0d", i), 1'b1, 32'(8 + 4 * i), 32'(32'h1000 + i), 1'b1);
            check($sformatf("stream%0d.stall", i), 64'(stall_cycles), 64'd0);
        end

        // Drain: last entry consumed with nothing new behind it.
        drive(1'b0, '0, '0, 1'b1);
        step();
        expect_out("drain", 1'b0, 32'd4, 32'd0, 1'b1);

        // Backpressure into the skid slot.
        drive(1'b1, 32'd8, 32'h0800, 1'b1);
        step();
        expect_out("bp.full", 1'b1, 32'd8, 32'h0800, 1'b1);
        drive(1'b1, 32'd12, 32'h0c00, 1'b0);
        step();
        expect_out("bp.skid", 1'b1, 32'd8, 32'h0800, 1'b0);
        check("bp.stall1", 64'(stall_cycles), 64'd1);
        drive(1'b1, 32'd16, 32'h1600, 1'b0);
        step();
        expect_out("bp.hold1", 1'b1, 32'd8, 32'h0800, 1'b0);
        step();
        expect_out("bp.hold2", 1'b1, 32'd8, 32'h0800, 1'b0);
        check("bp.stall3", 64'(stall_cycles), 64'd3);
        decode_ch.ready = 1'b1;
        step();
        expect_out("bp.deq12", 1'b1, 32'd12, 32'h0c00, 1'b1);
        check("bp.stall_kept", 64'(stall_cycles), 64'd3);
        step();
        expect_out("bp.deq16", 1'b1, 32'd16, 32'h1600, 1'b1);
        fetch_ch.valid = 1'b0;
        step();
        expect_out("bp.empty", 1'b0, 32'd4, 32'd0, 1'b1);

        // Flush while parked in the skid slot, fetch still offering.
        drive(1'b1, 32'd24, 32'h0011, 1'b1);
        step();
        drive(1'b1, 32'd28, 32'h00A00093, 1'b0);
        step();
        expect_out("fl.skid", 1'b1, 32'd24, 32'h0011, 1'b0);
        check("fl.stall_pre", 64'(stall_cycles), 64'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_out("fl.after", 1'b0, 32'd4, 32'd0, 1'b1);
        check("fl.stall", 64'(stall_cycles), 64'd5);
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            expect_out($sformatf("fl.gone%0d", i), 1'b0, 32'd4, 32'd0, 1'b1);
        end

        // Counter saturation with a 4-bit counter, starting from 5.
        drive(1'b1, 32'd32, 32'h0022, 1'b0);
        step();
        fetch_ch.valid = 1'b0;
        check("sat.start", 64'(stall_cycles), 64'd5);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 5)  check("sat.k5", 64'(stall_cycles), 64'd10);
            if (k == 10) check("sat.k10", 64'(stall_cycles), 64'd15);
        end
        check("sat.k20", 64'(stall_cycles), 64'd15);
        expect_out("sat.held", 1'b1, 32'd32, 32'h0022, 1'b1);

        // Asynchronous reset while in SKID, between clock edges.
        drive(1'b1, 32'd36, 32'h0033, 1'b0);
        step();
        expect_out("ar.skid", 1'b1, 32'd32, 32'h0022, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("ar.now", 1'b0, 32'd4, 32'd0, 1'b1);
        check("ar.stall", 64'(stall_cycles), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
